// File: rtl/fifo_arbiter_pkg.sv
// Shared state encoding, FIFO status constants and helpers for fifo_arbiter.
package fifo_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [2:0] FIFO_EMPTY = 3'd0;
  localparam logic [2:0] FIFO_FULL  = 3'd5;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fifo_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  id_o,
  output logic            any_o
);

  int idx;

  always_comb begin
    id_o  = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[idx]) begin
        any_o = 1'b1;
        id_o  = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter sharing the fifo_wrapper read port; one outstanding read at a time.
// Optional `ERR_CNT_EN adds a saturating error-response counter (err_cnt, err_cnt_clr).
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int IDW      = 1,
  parameter int WIDTH    = 32,
  parameter int ERRDATA  = 6,
  parameter int ERRPTR   = 4,
  parameter int READ_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_pop,
  output logic [NREQ-1:0]    gnt,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_empty,
  output logic               rsp_err,
  output logic               rsp_ptr_err,
  output logic               busy,
  input  logic [2:0]         fifo_status,
  input  logic [WIDTH-1:0]   fifo_out_reg,
  input  logic [ERRDATA-1:0] data_err_idx_reg,
  input  logic [ERRPTR-1:0]  wr_ptr_err_idx_reg,
  input  logic [ERRPTR-1:0]  rd_ptr_err_idx_reg,
  output logic               arbiter_rd_en,
  output logic               arbiter_rd_only
`ifdef ERR_CNT_EN
  ,
  output logic [15:0]        err_cnt,
  input  logic               err_cnt_clr
`endif
);

  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   id_q, id_d, rr_q, rr_d, win_id;
  logic             win_any;
  logic             pop_q, pop_d, empty_q, empty_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d, perr_q, perr_d;
  logic [NREQ-1:0]  id_onehot;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i (req),
    .ptr_i (rr_q),
    .id_o  (win_id),
    .any_o (win_any)
  );

  assign id_onehot = {{(NREQ-1){1'b0}}, 1'b1} << id_q;

  always_comb begin
    state_d         = state_q;
    id_d            = id_q;
    rr_d            = rr_q;
    pop_d           = pop_q;
    empty_d         = empty_q;
    cnt_d           = cnt_q;
    data_d          = data_q;
    err_d           = err_q;
    perr_d          = perr_q;
    gnt             = '0;
    arbiter_rd_en   = 1'b0;
    arbiter_rd_only = 1'b0;
    rsp_valid       = 1'b0;
    rsp_id          = '0;
    rsp_data        = '0;
    rsp_empty       = 1'b0;
    rsp_err         = 1'b0;
    rsp_ptr_err     = 1'b0;
    busy            = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          id_d   = win_id;
          pop_d  = req_pop[win_id];
          rr_d   = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
          data_d = '0;
          err_d  = 1'b0;
          perr_d = 1'b0;
          // An empty FIFO is answered without touching the read port.
          if (fifo_status == FIFO_EMPTY) begin
            empty_d = 1'b1;
            state_d = ST_RESP;
          end else begin
            empty_d = 1'b0;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        gnt             = id_onehot;
        arbiter_rd_en   = 1'b1;
        arbiter_rd_only = ~pop_q;
        cnt_d           = CW'(READ_LAT - 1);
        state_d         = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          data_d  = fifo_out_reg;
          err_d   = |data_err_idx_reg;
          perr_d  = (|wr_ptr_err_idx_reg) | (|rd_ptr_err_idx_reg);
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        gnt         = empty_q ? id_onehot : '0;
        rsp_valid   = 1'b1;
        rsp_id      = id_q;
        rsp_data    = data_q;
        rsp_empty   = empty_q;
        rsp_err     = err_q;
        rsp_ptr_err = perr_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      rr_q    <= '0;
      pop_q   <= 1'b0;
      empty_q <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      pop_q   <= pop_d;
      empty_q <= empty_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
    end
  end

`ifdef ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (state_q == ST_RESP && (err_q || perr_q)) begin
      err_cnt_d = sat_inc16(err_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
